// File: rtl/centroid_accumulator_if.sv
// Bundle of handshake and bus signals around centroid_accumulator.
//   Sample stream : in_valid, in_ready, in_sof, in_eof, in_pos, in_weight
//   Divider side  : div_en, div_dividend, div_divisor, div_quotient, div_done
//   Result stream : out_valid, out_ready, out_centroid, out_count,
//                   out_empty, out_overflow
// Modports:
//   slave  - the accumulator itself (consumes samples, drives the divider,
//            produces results)
//   master - the surrounding environment (sample source, divider, result sink)
interface centroid_accumulator_if #(
    parameter int POS_W = 16,
    parameter int WT_W  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic             in_eof;
    logic [POS_W-1:0] in_pos;
    logic [WT_W-1:0]  in_weight;

    logic             div_en;
    logic [63:0]      div_dividend;
    logic [63:0]      div_divisor;
    logic [31:0]      div_quotient;
    logic             div_done;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_centroid;
    logic [15:0]      out_count;
    logic             out_empty;
    logic             out_overflow;

    modport slave (
        input  in_valid, in_sof, in_eof, in_pos, in_weight,
        output in_ready,
        output div_en, div_dividend, div_divisor,
        input  div_quotient, div_done,
        output out_valid, out_centroid, out_count, out_empty, out_overflow,
        input  out_ready
    );

    modport master (
        output in_valid, in_sof, in_eof, in_pos, in_weight,
        input  in_ready,
        input  div_en, div_dividend, div_divisor,
        output div_quotient, div_done,
        input  out_valid, out_centroid, out_count, out_empty, out_overflow,
        output out_ready
    );
endinterface

// File: rtl/centroid_accumulator.sv
// Weighted-centroid front end for binary_divider.
// Accumulates sum(w*p) and sum(w) over a frame delimited by sof/eof, hands
// (sum(w*p) << FRAC_BITS) and sum(w) to the divider, captures the quotient
// and presents one result per frame.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - centroid_accumulator_if.slave: sample stream in, divider
//           start/operands out, divider quotient/done in, result stream out
// All outputs are registered except bus.in_ready, which decodes the state.
module centroid_accumulator #(
    parameter int POS_W     = 16,
    parameter int WT_W      = 16,
    parameter int FRAC_BITS = 8
) (
    input logic                   clk,
    input logic                   reset,
    centroid_accumulator_if.slave bus
);
    localparam int NUM_W    = 48;
    localparam int DEN_W    = 32;
    localparam int PROD_W   = POS_W + WT_W;
    localparam int SCALED_W = NUM_W + FRAC_BITS;

    typedef enum logic [1:0] {
        ACCUM,
        ISSUE,
        WAIT_DIV,
        OUTPUT
    } state_t;

    state_t            state_reg;
    logic              frame_open_reg;
    logic [NUM_W-1:0]  num_reg;
    logic [DEN_W-1:0]  den_reg;
    logic [15:0]       count_reg;
    logic              overflow_reg;
    logic              empty_reg;
    logic              div_en_reg;
    logic [63:0]       dividend_reg;
    logic [63:0]       divisor_reg;
    logic              out_valid_reg;
    logic [31:0]       centroid_reg;

    logic [PROD_W-1:0]   product;
    logic [NUM_W-1:0]    num_add;
    logic [DEN_W-1:0]    den_add;
    logic [NUM_W-1:0]    num_next;
    logic [DEN_W-1:0]    den_next;
    logic [15:0]         count_next;
    logic                overflow_next;
    logic [SCALED_W-1:0] scaled_num;
    logic [63:0]         dividend_next;

    // Operands are zero-extended so the product keeps its full width.
    assign product = {{WT_W{1'b0}}, bus.in_pos} * {{POS_W{1'b0}}, bus.in_weight};

    always_comb begin
        num_add                = '0;
        num_add[PROD_W-1:0]    = product;
        den_add                = '0;
        den_add[WT_W-1:0]      = bus.in_weight;
    end

    // A sof sample restarts the sums with itself; otherwise it adds on.
    always_comb begin
        num_next      = bus.in_sof ? num_add : num_reg + num_add;
        den_next      = bus.in_sof ? den_add : den_reg + den_add;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (bus.in_sof) begin
            count_next    = 16'd1;
            overflow_next = 1'b0;
        end else if (count_reg == 16'hFFFF) begin
            overflow_next = 1'b1;
        end else begin
            count_next = count_reg + 16'd1;
        end
    end

    assign scaled_num = {num_next, {FRAC_BITS{1'b0}}};

    // Map the scaled numerator onto the 64-bit divider bus, truncating or
    // zero-padding depending on FRAC_BITS.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_dividend
            if (gi < SCALED_W) begin : g_bit
                assign dividend_next[gi] = scaled_num[gi];
            end else begin : g_pad
                assign dividend_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ACCUM;
            frame_open_reg <= 1'b0;
            num_reg        <= '0;
            den_reg        <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            empty_reg      <= 1'b0;
            div_en_reg     <= 1'b0;
            dividend_reg   <= '0;
            divisor_reg    <= '0;
            out_valid_reg  <= 1'b0;
            centroid_reg   <= '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    // Samples outside an open frame are dropped silently.
                    if (bus.in_valid && (bus.in_sof || frame_open_reg)) begin
                        num_reg        <= num_next;
                        den_reg        <= den_next;
                        count_reg      <= count_next;
                        overflow_reg   <= overflow_next;
                        frame_open_reg <= 1'b1;
                        if (bus.in_sof) begin
                            empty_reg <= 1'b0;
                        end
                        if (bus.in_eof) begin
                            frame_open_reg <= 1'b0;
                            if (den_next == '0) begin
                                // Nothing to divide by: report an empty frame.
                                empty_reg     <= 1'b1;
                                centroid_reg  <= '0;
                                out_valid_reg <= 1'b1;
                                state_reg     <= OUTPUT;
                            end else begin
                                div_en_reg    <= 1'b1;
                                dividend_reg  <= dividend_next;
                                divisor_reg   <= {32'b0, den_next};
                                state_reg     <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    div_en_reg <= 1'b0;
                    state_reg  <= WAIT_DIV;
                end
                WAIT_DIV: begin
                    // The divider only presents its quotient during div_done.
                    if (bus.div_done) begin
                        centroid_reg  <= bus.div_quotient;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ACCUM;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready     = (state_reg == ACCUM);
    assign bus.div_en       = div_en_reg;
    assign bus.div_dividend = dividend_reg;
    assign bus.div_divisor  = divisor_reg;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_centroid = centroid_reg;
    // Count and overflow only move in ACCUM, so they are stable in OUTPUT.
    assign bus.out_count    = count_reg;
    assign bus.out_empty    = empty_reg;
    assign bus.out_overflow = overflow_reg;
endmodule

// File: tb/tb_centroid_accumulator.sv
module tb_centroid_accumulator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    centroid_accumulator_if #(.POS_W(16), .WT_W(16)) bus ();

    centroid_accumulator #(
        .POS_W(16), .WT_W(16), .FRAC_BITS(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] centroid;
        logic [15:0] count;
        logic        empty;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] dividend;
        logic [63:0] divisor;
    } div_t;

    res_t exp_q[$];
    div_t div_q[$];

    int checks = 0;
    int fails = 0;
    int div_lat = 3;
    int div_pulses = 0;
    int stray_req = 0;
    int stray_done = 0;
    int results = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [31:0] c, input logic [15:0] n, input logic e, input logic o);
        res_t r;
        r.centroid = c;
        r.count    = n;
        r.empty    = e;
        r.ovf      = o;
        exp_q.push_back(r);
    endtask

    task automatic expect_div(input logic [63:0] dd, input logic [63:0] dv);
        div_t d;
        d.dividend = dd;
        d.divisor  = dv;
        div_q.push_back(d);
    endtask

    // Drive one sample and wait (bounded) until it is accepted.
    // Returns #1 after the accepting edge.
    task automatic send(input logic [15:0] p, input logic [15:0] w, input logic s, input logic e);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.in_pos    = p;
        bus.in_weight = w;
        bus.in_sof    = s;
        bus.in_eof    = e;
        bus.in_valid  = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            n++;
        end
        chk("send_accepted", ok, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        $display("sample pos=%0d weight=%0d sof=%0b eof=%0b", p, w, s, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_results", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},     bus.in_ready, 1);
        chk({tag, "_div_en"},       bus.div_en, 0);
        chk({tag, "_div_dividend"}, bus.div_dividend, 0);
        chk({tag, "_div_divisor"},  bus.div_divisor, 0);
        chk({tag, "_out_valid"},    bus.out_valid, 0);
        chk({tag, "_out_centroid"}, bus.out_centroid, 0);
        chk({tag, "_out_count"},    bus.out_count, 0);
        chk({tag, "_out_empty"},    bus.out_empty, 0);
        chk({tag, "_out_overflow"}, bus.out_overflow, 0);
    endtask

    // Divider model: checks operands on div_en, returns quotient after
    // div_lat cycles as a one-cycle pulse, then scrambles the quotient bus.
    initial begin
        logic [63:0] q;
        int          cnt;
        logic        busy;
        div_t        d;
        busy = 1'b0;
        cnt  = 0;
        q    = '0;
        bus.div_done     = 1'b0;
        bus.div_quotient = '0;
        forever begin
            @(negedge clk);
            if (bus.div_done) begin
                bus.div_done     = 1'b0;
                bus.div_quotient = 32'hDEADBEEF;
            end
            if (reset) begin
                busy = 1'b0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                bus.div_done     = 1'b1;
                bus.div_quotient = 32'h12345678;
            end else if (bus.div_en) begin
                div_pulses++;
                chk("div_issue_expected", div_q.size() != 0, 1'b1);
                if (div_q.size() != 0) begin
                    d = div_q.pop_front();
                    chk("div_dividend", bus.div_dividend, d.dividend);
                    chk("div_divisor",  bus.div_divisor,  d.divisor);
                end
                $display("divide %0d / %0d", bus.div_dividend, bus.div_divisor);
                q    = (bus.div_divisor != 0) ? bus.div_dividend / bus.div_divisor : '1;
                busy = 1'b1;
                cnt  = div_lat;
            end else if (busy) begin
                if (cnt <= 1) begin
                    bus.div_done     = 1'b1;
                    bus.div_quotient = q[31:0];
                    busy             = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Result monitor: compares every accepted result against the scoreboard.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                chk("result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_centroid", bus.out_centroid, e.centroid);
                    chk("out_count",    bus.out_count,    e.count);
                    chk("out_empty",    bus.out_empty,    e.empty);
                    chk("out_overflow", bus.out_overflow, e.ovf);
                end
                results++;
                $display("result %0d: centroid=0x%08h count=%0d empty=%0b overflow=%0b",
                         results, bus.out_centroid, bus.out_count, bus.out_empty, bus.out_overflow);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_eof    = 1'b0;
        bus.in_pos    = '0;
        bus.in_weight = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset("reset");

        // Basic three-sample frame: (10+20+60)<<8 / 4 = 5760
        expect_div(64'd23040, 64'd4);
        expect_res(32'd5760, 16'd3, 1'b0, 1'b0);
        send(16'd10, 16'd1, 1'b1, 1'b0);
        send(16'd20, 16'd1, 1'b0, 1'b0);
        send(16'd30, 16'd2, 1'b0, 1'b1);
        chk("A_div_en_T1", bus.div_en, 1);
        @(posedge clk);
        #1;
        chk("A_div_en_one_cycle", bus.div_en, 0);
        chk("A_in_ready_busy", bus.in_ready, 0);
        drain();

        // Zero-weight single sample: empty result at T+1, no divide
        expect_res(32'd0, 16'd1, 1'b1, 1'b0);
        send(16'd100, 16'd0, 1'b1, 1'b1);
        chk("E_out_valid_T1", bus.out_valid, 1);
        chk("E_no_div_en", bus.div_en, 0);
        drain();

        // Result held with out_ready low; next frame waits for the handshake
        bus.out_ready = 1'b0;
        expect_div(64'd5120, 64'd4);
        expect_res(32'd1280, 16'd2, 1'b0, 1'b0);
        send(16'd4, 16'd2, 1'b1, 1'b0);
        send(16'd6, 16'd2, 1'b0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("B_out_valid_seen", bus.out_valid, 1);
        expect_div(64'd51200, 64'd4);
        expect_res(32'd12800, 16'd1, 1'b0, 1'b0);
        fork
            send(16'd50, 16'd4, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("B_hold_out_valid", bus.out_valid, 1);
                    chk("B_hold_centroid",  bus.out_centroid, 1280);
                    chk("B_hold_count",     bus.out_count, 2);
                    chk("B_hold_in_ready",  bus.in_ready, 0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Samples outside a frame are discarded, then a mid-frame sof restarts
        send(16'd7, 16'd7, 1'b0, 1'b0);
        send(16'd9, 16'd9, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("D_discard_no_div_en", bus.div_en, 0);
        chk("D_discard_in_ready",  bus.in_ready, 1);
        chk("D_discard_no_valid",  bus.out_valid, 0);
        expect_div(64'd5120, 64'd2);
        expect_res(32'd2560, 16'd2, 1'b0, 1'b0);
        send(16'd5,  16'd3, 1'b1, 1'b0);
        send(16'd8,  16'd1, 1'b1, 1'b0);
        send(16'd12, 16'd1, 1'b0, 1'b1);
        drain();

        // Reset while waiting on the divider; stray div_done afterwards
        div_lat = 30;
        expect_div(64'd23040, 64'd4);
        send(16'd10, 16'd1, 1'b1, 1'b0);
        send(16'd20, 16'd1, 1'b0, 1'b0);
        send(16'd30, 16'd2, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset("midreset");
        stray_req++;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("stray_no_valid",    bus.out_valid, 0);
        chk("stray_in_ready",    bus.in_ready, 1);
        chk("stray_centroid",    bus.out_centroid, 0);
        div_lat = 3;

        // Frame after reset: (2+4+18)<<8 / 4 = 1536
        expect_div(64'd6144, 64'd4);
        expect_res(32'd1536, 16'd3, 1'b0, 1'b0);
        send(16'd2, 16'd1, 1'b1, 1'b0);
        send(16'd4, 16'd1, 1'b0, 1'b0);
        send(16'd9, 16'd2, 1'b0, 1'b1);
        drain();

        // Full-scale samples: 4*0xFFFE0001 << 8 over 4*0xFFFF
        expect_div(64'h3FF_F800_0400, 64'h3FFFC);
        expect_res(32'h00FFFF00, 16'd4, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        drain();

        chk("final_div_queue_empty", div_q.size(), 0);
        chk("final_div_pulses", div_pulses, 7);
        chk("final_results", results, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
